// File: rtl/mem_pkg.sv
// Shared types for the memory-controller data port: width codes, arbiter states, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Access width codes as seen on the controller's width input; any other value means word.
  localparam logic [1:0] WIDTH_BYTE = 2'd1;
  localparam logic [1:0] WIDTH_HALF = 2'd2;
  localparam logic [1:0] WIDTH_WORD = 2'd3;

  // ARB: free arbitration; LOCK0/LOCK1: port owned by M0/M1 until its next unlocked access.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // One requester's access fields, bundled so the 2:1 mux is a single select.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        we;
    logic        zeroextend;
    logic        lock;
  } mem_req_t;

endpackage

// File: rtl/data_port_arbiter_if.sv
// Bundle of both requester ports plus the controller-side data port.
// Latency: n/a (wires only).
// Backpressure: requesters hold their fields until gnt; the controller side never stalls.
interface data_port_arbiter_if;

  logic        i_m0_req;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic [1:0]  i_m0_width;
  logic        i_m0_we;
  logic        i_m0_zeroextend;
  logic        i_m0_lock;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic [31:0] o_m0_rdata;

  logic        i_m1_req;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic [1:0]  i_m1_width;
  logic        i_m1_we;
  logic        i_m1_zeroextend;
  logic        i_m1_lock;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_m1_rdata;

  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_width;
  logic        o_mem_we;
  logic        o_mem_zeroextend;
  logic [31:0] i_mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_width, i_m0_we, i_m0_zeroextend, i_m0_lock,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_width, i_m1_we, i_m1_zeroextend, i_m1_lock,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zeroextend,
    input  i_mem_rdata
  );

  // Requesters plus controller model side.
  modport master (
    output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_width, i_m0_we, i_m0_zeroextend, i_m0_lock,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
    output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_width, i_m1_we, i_m1_zeroextend, i_m1_lock,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zeroextend,
    output i_mem_rdata
  );

endinterface

// File: rtl/data_port_arbiter.sv
// Two-master arbiter for the memory controller data port: M0 priority, M1 anti-starvation, lock.
// Latency: grant and port mux are combinational; read data returns 1 cycle after grant.
// Backpressure: a denied master keeps req and fields stable until its gnt cycle.
module data_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  data_port_arbiter_if.slave  bus
);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             resp_valid;
  logic             resp_owner;

  mem_req_t m0_r;
  mem_req_t m1_r;
  mem_req_t win;
  logic     m0_gnt;
  logic     m1_gnt;
  logic     any_gnt;
  logic     starve_hit;
  logic     m0_rvalid;
  logic     m1_rvalid;

  assign m0_r = '{addr: bus.i_m0_addr, wdata: bus.i_m0_wdata, width: bus.i_m0_width,
                  we: bus.i_m0_we, zeroextend: bus.i_m0_zeroextend, lock: bus.i_m0_lock};
  assign m1_r = '{addr: bus.i_m1_addr, wdata: bus.i_m1_wdata, width: bus.i_m1_width,
                  we: bus.i_m1_we, zeroextend: bus.i_m1_zeroextend, lock: bus.i_m1_lock};

  assign starve_hit = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Pick at most one winner; reset gates grants so every output is quiet while in reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (i_rst_n) begin
      unique case (state)
        ARB: begin
          if (bus.i_m1_req && (!bus.i_m0_req || starve_hit)) m1_gnt = 1'b1;
          else if (bus.i_m0_req)                              m0_gnt = 1'b1;
        end
        LOCK0:   m0_gnt = bus.i_m0_req;
        LOCK1:   m1_gnt = bus.i_m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;
  // With no winner the mux yields all-zero fields, so o_mem_we cannot leak a stale write.
  assign win     = m1_gnt ? m1_r : (m0_gnt ? m0_r : '0);

  assign bus.o_m0_gnt         = m0_gnt;
  assign bus.o_m1_gnt         = m1_gnt;
  assign bus.o_mem_addr       = win.addr;
  assign bus.o_mem_wdata      = win.wdata;
  assign bus.o_mem_width      = win.width;
  assign bus.o_mem_we         = win.we;
  assign bus.o_mem_zeroextend = win.zeroextend;

  // Lock ownership: only the owner's granted access can change state; lock bit picks stay/leave.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ARB;
    end else if (m0_gnt) begin
      state <= m0_r.lock ? LOCK0 : ARB;
    end else if (m1_gnt) begin
      state <= m1_r.lock ? LOCK1 : ARB;
    end
  end

  // Count consecutive denied M1 cycles in ARB; frozen while M0 holds the lock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (m1_gnt || !bus.i_m1_req) begin
      starve_cnt <= '0;
    end else if (state == ARB) begin
      if (starve_cnt != {CNT_W{1'b1}}) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Remember which master issued a read so the 1-cycle-late data is steered back to it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      resp_valid <= any_gnt & ~win.we;
      if (any_gnt) resp_owner <= m1_gnt;
    end
  end

  assign m0_rvalid = resp_valid & ~resp_owner;
  assign m1_rvalid = resp_valid &  resp_owner;

  assign bus.o_m0_rvalid = m0_rvalid;
  assign bus.o_m1_rvalid = m1_rvalid;
  assign bus.o_m0_rdata  = m0_rvalid ? bus.i_mem_rdata : 32'h0;
  assign bus.o_m1_rdata  = m1_rvalid ? bus.i_mem_rdata : 32'h0;

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single data port of the memory controller between two requesters: M0, the CPU load/store unit, and M1, the debug/loader master that fills instruction RAM and pokes GPIO.
- Sits between the requesters and the controller's data-side inputs (addr, wdata, width, we, zeroextend) and its 1-cycle-latency read data output.
- Grants one access per cycle:
  - M0 has priority.
  - A starvation counter guarantees M1 progress.
  - A lock lets a master own the port for multi-access sequences.
- Routes each read response back to the master that issued it.

Parameters:
STARVE_LIMIT, 8, consecutive cycles M1 may be denied (while requesting, not locked out) before it wins over M0; range 1..255
CNT_W, 8, width of starvation counter; must hold STARVE_LIMIT

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_m0_req  input  1  M0 access request
i_m0_addr  input  32  M0 byte address
i_m0_wdata  input  32  M0 write data
i_m0_width  input  2  1=byte, 2=half, other=word
i_m0_we  input  1  M0 write enable
i_m0_zeroextend  input  1  M0 load zero-extend
i_m0_lock  input  1  keep ownership after this access
o_m0_gnt  output  1  M0 access accepted this cycle
o_m0_rvalid  output  1  M0 read data valid
o_m0_rdata  output  32  M0 read data
i_m1_*, o_m1_*  same set and widths as M0, for M1
o_mem_addr  output  32  to controller i_data_addr
o_mem_wdata  output  32  to controller i_data_data
o_mem_width  output  2  to controller i_data_width
o_mem_we  output  1  to controller i_data_we
o_mem_zeroextend  output  1  to controller i_data_zeroextend
i_mem_rdata  input  32  from controller o_data_data, valid 1 cycle after address

Behaviour:
Interface and reset:
- One clock, i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=ARB, starve_cnt=0, resp_valid=0, resp_owner=0.
- In reset, all o_* are 0.

Grant:
- Combinational from state, the req lines and starve_cnt.
- At most one gnt high per cycle. A request is accepted in the cycle gnt is high. The master holds its request fields stable until granted.
- State ARB:
  - M1 wins if i_m1_req and (not i_m0_req or starve_cnt >= STARVE_LIMIT).
  - Otherwise M0 wins if i_m0_req.
- State LOCK0: only M0 can be granted; M1 is denied.
- State LOCK1: only M1 can be granted; M0 is denied.

Port mux:
- The winner's addr/wdata/width/we/zeroextend drive o_mem_* in the grant cycle.
- With no grant: o_mem_we=0 and o_mem_addr/wdata/width/zeroextend=0, so no write can occur.

State transitions, on a granted access by master X:
- lock=1 enters or stays in LOCKX.
- lock=0 returns to ARB.
- Without a grant, the state holds. A lock is released only by the owner's unlocked access; reset is the only other exit.

Starvation counter:
- Increments (saturating at 2^CNT_W-1) each cycle i_m1_req=1 and o_m1_gnt=0 while state is ARB.
- Clears to 0 when M1 is granted or i_m1_req=0.
- Holds during LOCK0.

Response routing:
- resp_valid <= granted & ~we; resp_owner <= index of the granted master.
- o_mX_rvalid = resp_valid & (resp_owner==X).
- o_mX_rdata = i_mem_rdata when o_mX_rvalid is high, else 0.
- Read latency is exactly 1 cycle after gnt.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle, including alternating owners.

Boundaries:
- Simultaneous requests with starve_cnt < limit: M0 wins.
- Simultaneous requests at the limit: M1 wins once and the counter clears.
- Reset asserted mid-transaction drops any pending rvalid immediately (async) and unlocks.
- A lock requested together with a write behaves like a lock requested together with a read.

Decomposition:
- Shared package mem_pkg holds:
  - width encodings WIDTH_BYTE=1, WIDTH_HALF=2, WIDTH_WORD=3.
  - typedef enum arb_state_t {ARB, LOCK0, LOCK1}.
  - packed struct mem_req_t {addr, wdata, width, we, zeroextend, lock}.
- No sub-module: the 2:1 mux, FSM, counter and response register are all small and live in one module.

Test Plan:
- M0 read only, addr 0x4000_0010, i_mem_rdata=0xDEADBEEF next cycle -> o_m0_gnt same cycle, o_m0_rvalid=1 with 0xDEADBEEF one cycle later, o_m1_rvalid=0.
- Both requesting continuously, STARVE_LIMIT=8 -> M0 granted 8 cycles, M1 granted on the 9th, then M0 resumes; counter reads 0 after the M1 grant.
- M1 issues 3 writes to 0x2000_0000..0x2000_0008 with lock=1,1,0 while M0 requests -> o_mem_we=1 with M1 data on all 3, o_m0_gnt=0 until after the third, then M0 granted next cycle.
- Alternating grants M0 read / M1 read / M0 write in consecutive cycles -> rvalid appears on M0 then M1 in consecutive cycles, no rvalid for the write.
- Assert i_rst_n=0 for one cycle while in LOCK1 with a pending read response -> all o_* drop to 0 asynchronously; after release, state is ARB and M0 is granted on its next request.
- No requests -> o_mem_we=0 and o_mem_addr=0 every cycle; no gnt or rvalid.
